// File: rtl/present_inv_round.sv
// -----------------------------------------------------------------------------
// present_inv_round
//
// One inverse (decryption) round of the PRESENT block cipher, built as a
// two-stage valid/ready pipeline.
//
//   Normal round   (in_last = 0): out = InvS(InvP(in_state)) ^ in_key
//   Whitening round(in_last = 1): out = in_state ^ in_key
//
// Stage 1 registers the inverse bit permutation (or the raw state for a
// whitening round) together with the key and the last flag. Stage 2 applies
// the inverse S-box layer and the key XOR and holds the result until the
// downstream consumer takes it.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   upstream offers in_state / in_key / in_last
//   in_ready   out  1   block accepts input this cycle
//   in_state   in  64   ciphertext or intermediate decryption state
//   in_key     in  64   round key for this round (already reverse-scheduled)
//   in_last    in   1   1 = whitening-only round
//   out_valid  out  1   out_state holds a valid result
//   out_ready  in   1   downstream accepts the result this cycle
//   out_state  out 64   decrypted round result
// -----------------------------------------------------------------------------
module present_inv_round (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_state,
    input  logic [63:0] in_key,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_state
);

    // -------------------------------------------------------------------------
    // Cipher layers
    // -------------------------------------------------------------------------

    // Inverse PRESENT S-box for a single nibble.
    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            4'hF: y = 4'hA;
        endcase
        return y;
    endfunction

    // Inverse S-box applied to all sixteen nibbles independently.
    function automatic logic [63:0] inv_slayer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sbox(s[4*n +: 4]);
        end
        return r;
    endfunction

    // Inverse bit permutation: input bit 16*b+k lands on output bit 4*k+b.
    // Pure wiring, no gates.
    function automatic logic [63:0] inv_player(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 16; k++) begin
                r[4*k + b] = s[16*b + k];
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    logic [63:0] s1_state_q, s1_state_d;
    logic [63:0] s1_key_q,   s1_key_d;
    logic        s1_last_q,  s1_last_d;

    logic        out_valid_q, out_valid_d;
    logic [63:0] out_state_q, out_state_d;

    logic        s2_adv;
    logic [63:0] s2_result;

    // Stage 2 may load whenever it is empty or its content leaves this cycle;
    // stage 1 may load whenever it is empty or it drains into stage 2. Both
    // are combinational so a full pipeline streams without bubbles.
    assign s2_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q  || s2_adv;

    // A whitening round carries the raw state through stage 1 and skips the
    // S-box layer here, leaving only the key XOR.
    assign s2_result = (s1_last_q ? s1_state_q : inv_slayer(s1_state_q)) ^ s1_key_q;

    // NOTE: every _d signal gets its hold value first so no path through this
    // block leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_state_d  = s1_state_q;
        s1_key_d    = s1_key_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            // Data is captured only on a real transfer; otherwise the inputs
            // are ignored and the stage keeps its previous contents.
            if (in_valid) begin
                s1_state_d = in_last ? in_state : inv_player(in_state);
                s1_key_d   = in_key;
                s1_last_d  = in_last;
            end
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_state_d = s2_result;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    // NOTE: the data registers are reset as well as the valid flags, so
    // out_state reads a defined zero while reset is asserted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_state_q  <= 64'h0;
            s1_key_q    <= 64'h0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= 64'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_state_q  <= s1_state_d;
            s1_key_q    <= s1_key_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

endmodule

// File: tb/tb_present_inv_round.sv
// -----------------------------------------------------------------------------
// tb_present_inv_round
//
// Self-checking bench for present_inv_round. Expected results come from a
// reference model built directly from the cipher definition (S-box tables
// and the P(i) = 16*i mod 63 rule) and a queue of in-flight results.
// -----------------------------------------------------------------------------
module tb_present_inv_round;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_state;
    logic [63:0] in_key;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;

    present_inv_round dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [3:0] sbox_t     [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] inv_sbox_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    function automatic int pmap(input int i);
        return (i == 63) ? 63 : (16 * i) % 63;
    endfunction

    // Decryption round: out bit i takes input bit P(i), then InvS, then key.
    function automatic logic [63:0] model(input logic [63:0] s, input logic [63:0] k,
                                          input logic l);
        logic [63:0] t, r;
        if (l) return s ^ k;
        for (int i = 0; i < 64; i++) t[i] = s[pmap(i)];
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox_t[t[4*n +: 4]];
        return r ^ k;
    endfunction

    // Encryption round: key XOR, S-box, then input bit i moves to bit P(i).
    function automatic logic [63:0] fwd_round(input logic [63:0] s, input logic [63:0] k);
        logic [63:0] t, u, r;
        t = s ^ k;
        for (int n = 0; n < 16; n++) u[4*n +: 4] = sbox_t[t[4*n +: 4]];
        for (int i = 0; i < 64; i++) r[pmap(i)] = u[i];
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q [$];
    int          n_out       = 0;

    logic        prev_stall  = 1'b0;
    logic [63:0] prev_out    = 64'h0;
    logic        s_out_valid;
    logic [63:0] s_out_state;
    logic        s_in_ready;
    logic        s_accept;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One clock with inputs already driven (called just after a falling
    // edge): sample, score, then advance to the next falling edge.
    task automatic cycle();
        #1;
        s_out_valid = out_valid;
        s_out_state = out_state;
        s_in_ready  = in_ready;
        s_accept    = in_valid && in_ready;

        check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
        if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_hold", out_state, prev_out);
        end
        if (out_valid) begin
            check("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("out_state", out_state, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
        if (s_accept) exp_q.push_back(model(in_state, in_key, in_last));

        prev_stall = out_valid && !out_ready;
        prev_out   = out_state;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Single transaction through an idle pipeline; reports result and the
    // number of clocks from the accepting edge to out_valid.
    task automatic run_one(input logic [63:0] st, input logic [63:0] k, input logic l,
                           output logic [63:0] res);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = st;
        in_key    = k;
        in_last   = l;
        cycle();
        check("accept", s_accept, 1'b1);
        in_valid = 1'b0;
        in_state = rnd64();
        lat      = 0;
        res      = 64'h0;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            if (s_out_valid) begin
                lat = c;
                res = s_out_state;
                break;
            end
        end
        check("latency", lat, 2);
    endtask

    // Reset asserted between edges, held for n edges with input offered,
    // released between edges.
    task automatic do_reset(input int n);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_state", out_state, 64'h0);
        check("rst_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_state = rnd64();
        in_key   = rnd64();
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            check("rst_hold_valid", out_valid, 1'b0);
            check("rst_hold_ready", in_ready, 1'b1);
        end
        exp_q.delete();
        prev_stall = 1'b0;
        in_valid   = 1'b0;
        reset_n    = 1'b1;
        @(negedge clock);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    logic [63:0] res, x, k, y;
    logic [63:0] keys [31];
    logic        pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          sent, base;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_state  = 64'h0;
        in_key    = 64'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        do_reset(3);

        // Nothing accepted during reset may emerge afterwards.
        for (int c = 0; c < 3; c++) cycle();

        // Known-answer vectors.
        run_one(64'hFFFFFFFF_00000000, 64'h0, 1'b0, res);
        check("kat_ff00", res, 64'h0000000000000000);
        run_one(64'h0, 64'h01234567_89ABCDEF, 1'b0, res);
        check("kat_key", res, 64'h54761032_DCFE98BA);
        run_one(64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, res);
        check("kat_ones", res, 64'hAAAAAAAA_AAAAAAAA);
        run_one(64'h1234, 64'hFFFF, 1'b1, res);
        check("kat_white", res, 64'hEDCB);

        // Eight back-to-back inputs against a stalling consumer.
        sent = 0;
        base = n_out;
        for (int c = 0; c < 80 && (sent < 8 || exp_q.size() != 0); c++) begin
            in_valid  = (sent < 8);
            in_state  = rnd64();
            in_key    = rnd64();
            in_last   = 1'b0;
            out_ready = pat[c % 6];
            cycle();
            if (s_accept) sent++;
        end
        in_valid = 1'b0;
        check("stream_sent", sent, 8);
        check("stream_recv", n_out - base, 8);
        check("stream_drain", exp_q.size(), 0);

        // Random traffic on both sides, including whitening rounds.
        sent = 0;
        base = n_out;
        for (int c = 0; c < 400 && (sent < 40 || exp_q.size() != 0); c++) begin
            in_valid  = (sent < 40) && ($urandom_range(3) != 0);
            in_state  = rnd64();
            in_key    = rnd64();
            in_last   = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(2) != 0);
            cycle();
            if (s_accept) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_recv", n_out - base, 40);
        check("rand_drain", exp_q.size(), 0);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_state = rnd64();
            in_key   = rnd64();
            in_last  = 1'b0;
            cycle();
        end
        check("flight_full", exp_q.size(), 2);
        do_reset(2);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        run_one(64'h0, 64'h0, 1'b0, res);
        check("post_rst", res, 64'h55555555_55555555);

        // Single-round round trips.
        for (int t = 0; t < 4; t++) begin
            x = rnd64();
            k = rnd64();
            run_one(fwd_round(x, k), k, 1'b0, res);
            check("rt_single", res, x);
        end

        // 31-round round trip, keys applied in reverse order.
        x = rnd64();
        y = x;
        for (int r = 0; r < 31; r++) begin
            keys[r] = rnd64();
            y = fwd_round(y, keys[r]);
        end
        for (int r = 30; r >= 0; r--) begin
            run_one(y, keys[r], 1'b0, res);
            y = res;
        end
        check("rt_31", y, x);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
